// File: rtl/dialogue_rx_pkg.sv
// Dialogue code and glyph constants shared by the screen modules, plus the
// code-to-glyph decode used wherever an opponent's dialogue is drawn.
package dialogue_rx_pkg;

  localparam logic [3:0] DLG_SMILE  = 4'd0;
  localparam logic [3:0] DLG_ANGRY  = 4'd1;
  localparam logic [3:0] DLG_SLEEPY = 4'd2;
  localparam logic [3:0] DLG_SHINE  = 4'd3;
  localparam logic [3:0] DLG_LOVE   = 4'd4;
  localparam logic [3:0] DLG_SAD    = 4'd5;
  localparam logic [3:0] DLG_LIKE   = 4'd6;
  localparam logic [3:0] DLG_7      = 4'd7;
  localparam logic [3:0] DLG_NONE   = 4'd8;

  localparam logic [7:0] GRAPH_SMILE  = 8'h80;
  localparam logic [7:0] GRAPH_ANGRY  = 8'h81;
  localparam logic [7:0] GRAPH_SLEEPY = 8'h82;
  localparam logic [7:0] GRAPH_SHINE  = 8'h83;
  localparam logic [7:0] GRAPH_LOVE   = 8'h84;
  localparam logic [7:0] GRAPH_SAD    = 8'h85;
  localparam logic [7:0] GRAPH_LIKE   = 8'h86;
  localparam logic [7:0] GRAPH_DLG7   = 8'h87;
  localparam logic [7:0] FONT_NONE    = 8'h20;

  // Codes 9-15 carry no emoticon; only the MSB separates them from 0-7.
  function automatic logic is_emoticon(input logic [3:0] code);
    return !code[3];
  endfunction

  function automatic logic [7:0] dlg_glyph(input logic [3:0] code);
    logic [7:0] g;
    case (code)
      DLG_SMILE:  g = GRAPH_SMILE;
      DLG_ANGRY:  g = GRAPH_ANGRY;
      DLG_SLEEPY: g = GRAPH_SLEEPY;
      DLG_SHINE:  g = GRAPH_SHINE;
      DLG_LOVE:   g = GRAPH_LOVE;
      DLG_SAD:    g = GRAPH_SAD;
      DLG_LIKE:   g = GRAPH_LIKE;
      DLG_7:      g = GRAPH_DLG7;
      default:    g = FONT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/dialogue_sync_qualify.sv
// Synchronizes the raw inter-board code and raises a one-cycle accept once a
// new value has been seen for STABLE_CYCLES consecutive samples.
module dialogue_sync_qualify
  import dialogue_rx_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] dialogue_i,
  output logic       accept_o,
  output logic [3:0] accept_code_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [3:0]    meta_q, sync_q, last_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid;

  // The counter holds how many samples the current sync value has been seen,
  // so it restarts at 1 on the edge where sync takes a new value.
  always_comb begin
    cnt_d = cnt_q;
    if (meta_q != sync_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign valid         = (cnt_q == CNT_MAX);
  assign accept_o      = valid && (sync_q != last_q);
  assign accept_code_o = sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= DLG_NONE;
      sync_q <= DLG_NONE;
      last_q <= DLG_NONE;
      cnt_q  <= '0;
    end else begin
      meta_q <= dialogue_i;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
      if (accept_o) begin
        last_q <= sync_q;
      end
    end
  end

endmodule

// File: rtl/dialogue_rx.sv
// Receive side of the dialogue link: qualified code held for HOLD_TICKS ticks,
// glyph decode and one-cycle new-message pulse, STABLE_CYCLES+1 clks after input.
module dialogue_rx #(
  parameter int STABLE_CYCLES = 4,
  parameter int HOLD_TICKS    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] dialogue_in,
  output logic [3:0] dialogue_code,
  output logic [7:0] dialogue_graph,
  output logic       new_msg
);
  import dialogue_rx_pkg::*;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

  logic          accept;
  logic [3:0]    accept_code;
  logic [0:0]    state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          new_msg_q, new_msg_d;

  dialogue_sync_qualify #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sq (
    .clk_i        (clk),
    .rst_i        (rst),
    .dialogue_i   (dialogue_in),
    .accept_o     (accept),
    .accept_code_o(accept_code)
  );

  // An emoticon accept outranks an expiring tick; non-emoticon accepts are
  // ignored so a released key does not blank the display early.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    hold_d    = hold_q;
    new_msg_d = 1'b0;
    if (accept && is_emoticon(accept_code)) begin
      state_d   = S_SHOW;
      code_d    = accept_code;
      hold_d    = HOLD_LOAD;
      new_msg_d = 1'b1;
    end else if (state_q == S_SHOW && tick) begin
      if (hold_q > HW'(1)) begin
        hold_d = hold_q - 1'b1;
      end else begin
        state_d = S_IDLE;
        code_d  = DLG_NONE;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      code_q    <= DLG_NONE;
      hold_q    <= '0;
      new_msg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      hold_q    <= hold_d;
      new_msg_q <= new_msg_d;
    end
  end

  assign dialogue_code  = code_q;
  assign dialogue_graph = dlg_glyph(code_q);
  assign new_msg        = new_msg_q;

endmodule

// File: doc/dialogue_rx.md
# dialogue_rx

Receive side of the inter-board dialogue link. Takes the raw 4-bit dialogue code driven by the other board's screen logic, synchronizes it and qualifies it for stability, then holds the accepted emoticon for a fixed display time. Its outputs are the qualified code, the 8-bit graph glyph for the shared 128-bit screen buffer, and a one-cycle new-message pulse. It sits between the inter-board pins and every screen module that shows the opponent's dialogue.

## Interface
- STABLE_CYCLES, 4: consecutive clk samples a code must hold before acceptance; legal range ≥2.
- HOLD_TICKS, 200: display time in `tick` pulses (200 = 2 s at 100 Hz); legal range ≥1.

- clk  in  1  global clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-clk-wide pulse at 100 Hz, synchronous to clk.
- dialogue_in  in  4  raw code from the other board, asynchronous. 0–7 are emoticons; 8 is none; 9–15 are treated as none.
- dialogue_code  out  4  code currently displayed; 8 when nothing is shown.
- dialogue_graph  out  8  glyph for dialogue_code.
- new_msg  out  1  one-clk pulse when a code 0–7 is accepted.

## Operation
- Two-flop synchronizer on dialogue_in feeds `sync`. The synchronizer resets to 8.
- Stability counter:
  - Cleared when `sync` differs from its previous-cycle value.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - The candidate is valid when the counter equals STABLE_CYCLES.
- Register `last_q` (reset 8) holds the last qualified value. An accept event occurs on the first valid cycle where the candidate ≠ last_q; last_q then loads the candidate. One event per stable value, with no repeats while the input stays held.
- FSM, two states:
  - IDLE (reset state): dialogue_code=8.
    - Accept event with candidate 0–7 → SHOW. Load the code, set hold_cnt=HOLD_TICKS, pulse new_msg.
  - SHOW:
    - Accept event with candidate 0–7 (same or different code) → stay in SHOW. Reload code and hold_cnt, pulse new_msg.
    - Accept event with candidate 8–15 → no effect. The sender releasing its key does not clear the display.
    - `tick` with hold_cnt>1 → decrement hold_cnt.
    - `tick` with hold_cnt==1 → IDLE, dialogue_code=8.
    - Simultaneous accept 0–7 and expiring tick → the accept wins (reload, stay in SHOW).
- The same code sent twice in a row is re-accepted only if a different stable value (normally 8) qualifies in between.
- dialogue_graph is decoded combinationally from dialogue_code:
  - 0 SMILE, 1 ANGRY, 2 SLEEPY, 3 SHINE, 4 LOVE, 5 SAD, 6 LIKE, 7 the eighth dialogue glyph.
  - Anything else → FONT_NONE.
- hold_cnt width is clog2(HOLD_TICKS+1); it never underflows.

## Timing
- Reset values: dialogue_code=8, dialogue_graph=FONT_NONE, new_msg=0, FSM IDLE, hold_cnt=0, stability counter 0, last_q=8.
- Latency: if dialogue_in changes before clk edge E0 and then holds, dialogue_code and new_msg update at edge E0+STABLE_CYCLES+1 (two synchronizer edges, then STABLE_CYCLES-1 further stable compares). new_msg is high for exactly one cycle.
- Glitches shorter than STABLE_CYCLES clk periods after synchronization never produce an accept event.
- Display lifetime: dialogue_code returns to 8 on the clk edge sampling the HOLD_TICKS-th `tick` after acceptance. A tick on the accept cycle itself is not counted.
- Asserting rst mid-SHOW forces all reset values immediately. After release, a code still held on dialogue_in is re-accepted after the normal latency, because last_q was reset to 8.

## Structure
- Dialogue code constants (DLG_NONE=4'd8, codes 0–7) belong in the shared global defines, next to the existing GRAPH_/FONT_ glyph defines. The glyph decode uses only those defines.
- One natural sub-module: `dialogue_sync_qualify` (synchronizer, stability counter, last_q). It emits `accept` and `accept_code`. The FSM, hold timer and glyph decode stay in the top.

## Test plan
Run with STABLE_CYCLES=4, HOLD_TICKS=5 and tick every 10 clks.

1. Reset, then drive dialogue_in=3 and hold → new_msg pulses once at E0+5. dialogue_code=3, dialogue_graph=SHINE. Exactly 5 ticks later dialogue_code=8 and graph=FONT_NONE.
2. Drive a 3-clk pulse of 5, then back to 8 → no new_msg, and dialogue_code stays 8.
3. Drive 1, then 8 after 20 clks, then 1 again while still in SHOW → two new_msg pulses. The hold timer restarts at the second accept, and the display clears 5 ticks after it.
4. Drive 2, then switch directly to 6 → new_msg pulses again and the code becomes 6 with a fresh timer. Then drive 12 → ignored, display unchanged until timeout.
5. Align a new accept of 4 with the expiring 5th tick → dialogue_code=4 stays shown, FSM remains SHOW, hold_cnt=5.
6. Assert rst during SHOW with dialogue_in held at 7 → outputs go to reset values asynchronously. After release, 7 is re-accepted with new_msg at the normal latency.
